// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start bit, DATA_BITS LSB-first, optional parity,
// one or two stop bits. Each bit is held for CLKS_PER_BIT clocks.
module uart_tx_frame #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_wr,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_uart_tx
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               state, state_n;
  logic [CW-1:0]        baud_cnt, baud_cnt_n;
  logic [IW-1:0]        bit_idx, bit_idx_n;
  logic                 stop_idx, stop_idx_n;
  logic [DATA_BITS-1:0] data_q, data_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 tx_q, tx_n;
  logic                 bit_end;
  logic                 parity_bit;

  assign bit_end    = (baud_cnt == BAUD_LAST);
  // data_q keeps the accepted word intact so parity never depends on live i_data
  assign parity_bit = (PARITY == 2) ? (^data_q) : ~(^data_q);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      data_q   <= '0;
      shreg    <= '0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_idx  <= bit_idx_n;
      stop_idx <= stop_idx_n;
      data_q   <= data_n;
      shreg    <= shreg_n;
      tx_q     <= tx_n;
    end
  end

  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_idx_n  = bit_idx;
    stop_idx_n = stop_idx;
    data_n     = data_q;
    shreg_n    = shreg;
    tx_n       = tx_q;
    if (state != S_IDLE) begin
      baud_cnt_n = bit_end ? '0 : baud_cnt + 1'b1;
    end
    unique case (state)
      S_IDLE: begin
        tx_n = 1'b1;
        if (i_wr) begin
          data_n     = i_data;
          shreg_n    = i_data;
          baud_cnt_n = '0;
          state_n    = S_START;
          tx_n       = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_n   = S_DATA;
          bit_idx_n = '0;
          tx_n      = shreg[0];
          shreg_n   = shreg >> 1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_idx == IDX_LAST) begin
            bit_idx_n  = '0;
            stop_idx_n = 1'b0;
            if (PARITY != 0) begin
              state_n = S_PARITY;
              tx_n    = parity_bit;
            end else begin
              state_n = S_STOP;
              tx_n    = 1'b1;
            end
          end else begin
            bit_idx_n = bit_idx + 1'b1;
            tx_n      = shreg[0];
            shreg_n   = shreg >> 1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_n    = S_STOP;
          stop_idx_n = 1'b0;
          tx_n       = 1'b1;
        end
      end
      S_STOP: begin
        tx_n = 1'b1;
        if (bit_end) begin
          if (stop_idx == STOP_LAST) begin
            state_n    = S_IDLE;
            stop_idx_n = 1'b0;
          end else begin
            stop_idx_n = 1'b1;
          end
        end
      end
      default: begin
        state_n    = S_IDLE;
        baud_cnt_n = '0;
        bit_idx_n  = '0;
        stop_idx_n = 1'b0;
        tx_n       = 1'b1;
      end
    endcase
  end

  assign o_busy    = (state != S_IDLE);
  assign o_done    = (state == S_STOP) && bit_end && (stop_idx == STOP_LAST);
  assign o_uart_tx = tx_q;

`ifdef FORMAL
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      assert (o_busy == (state != S_IDLE));
      assert ((state != S_IDLE) || o_uart_tx);
      assert (32'(baud_cnt) < CLKS_PER_BIT);
      assert (32'(bit_idx) < DATA_BITS);
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: several configurations run side by side, each with a
// randomized driver, an expected-frame queue and a per-cycle line monitor.
module tb_uart_tx_frame;

  localparam int N = 6;
  localparam int DB_T [N] = '{8, 8, 8, 7, 8, 9};
  localparam int CPB_T[N] = '{4, 2, 2, 3, 1, 3};
  localparam int PAR_T[N] = '{0, 2, 1, 0, 0, 2};
  localparam int SB_T [N] = '{1, 1, 1, 2, 1, 2};
  localparam logic [8:0] FIRST_T[N] = '{9'h0A5, 9'h007, 9'h007, 9'h07F, 9'h001, 9'h1B3};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int finished = 0;

  task automatic check(input string nm, input int id, input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t actual=%0h expected=%0h", nm, id, $time, act, exp);
    end
  endtask

  // Reference frame: bit k is the line level during the k-th bit slot of the frame.
  function automatic logic [15:0] frame_bits(input logic [8:0] w, input int db, input int par);
    logic [15:0] f;
    logic        p;
    f = '1;
    p = 1'b0;
    f[0] = 1'b0;
    for (int i = 0; i < db; i++) begin
      f[1+i] = w[i];
      p      = p ^ w[i];
    end
    if (par == 2) f[1+db] = p;
    else if (par == 1) f[1+db] = ~p;
    return f;
  endfunction

  for (genvar g = 0; g < N; g++) begin : u
    localparam int DB  = DB_T[g];
    localparam int CPB = CPB_T[g];
    localparam int PAR = PAR_T[g];
    localparam int SB  = SB_T[g];
    localparam int F   = 1 + DB + ((PAR != 0) ? 1 : 0) + SB;
    localparam int FC  = F * CPB;

    logic       rst  = 1'b1;
    logic       wr   = 1'b0;
    logic [8:0] data = '0;
    logic       busy, done, tx;

    logic [15:0] exp_q[$];
    logic        mon_en     = 1'b0;
    logic        in_frame   = 1'b0;
    logic        after_frame = 1'b0;
    int          pos        = 0;
    logic [15:0] cur        = '0;

    uart_tx_frame #(
      .DATA_BITS(DB), .CLKS_PER_BIT(CPB), .PARITY(PAR), .STOP_BITS(SB)
    ) dut (
      .i_clk(clk), .i_reset(rst), .i_data(data[DB-1:0]), .i_wr(wr),
      .o_busy(busy), .o_done(done), .o_uart_tx(tx)
    );

    task automatic tick();
      @(posedge clk);
      #1;
    endtask

    // mode 0: random ignored writes while busy; mode 1: hold i_wr with 0x0FF
    task automatic send(input logic [8:0] w, input int mode);
      wr   = 1'b1;
      data = w;
      exp_q.push_back(frame_bits(w, DB, PAR));
      tick();
      repeat (FC) begin
        if (mode == 1) begin
          wr   = 1'b1;
          data = 9'h0FF;
        end else begin
          wr   = 1'($urandom_range(0, 1));
          data = 9'($urandom);
        end
        tick();
      end
      wr = 1'b0;
    endtask

    initial begin
      logic [8:0] w;
      repeat (3) tick();
      rst    = 1'b0;
      mon_en = 1'b1;
      repeat (g + 2) tick();
      send(FIRST_T[g], 0);
      repeat ($urandom_range(0, 3)) tick();
      send(9'h03C, 1);
      send(9'h0FF, 0);
      repeat (2) tick();
      // abort during the third data bit, with a write held alongside the reset
      w    = 9'($urandom);
      wr   = 1'b1;
      data = w;
      exp_q.push_back(frame_bits(w, DB, PAR));
      tick();
      wr = 1'b0;
      repeat (3 * CPB) tick();
      rst = 1'b1;
      wr  = 1'b1;
      tick();
      rst = 1'b0;
      wr  = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
      send(9'h055, 0);
      for (int i = 0; i < 25; i++) begin
        repeat ($urandom_range(0, 4)) tick();
        send(9'($urandom), 0);
      end
      repeat (4) tick();
      check("frames_left", g, 16'(exp_q.size()), 16'd0);
      check("frame_open", g, 16'(in_frame), 16'd0);
      finished++;
    end

    always @(negedge clk) begin
      if (mon_en) begin
        if (!in_frame && !after_frame && busy) begin
          check("frame_expected", g, 16'(exp_q.size() > 0), 16'd1);
          if (exp_q.size() > 0) begin
            cur      = exp_q.pop_front();
            in_frame = 1'b1;
            pos      = 0;
          end
        end
        if (in_frame) begin
          check("busy_in_frame", g, 16'(busy), 16'd1);
          check("tx_bit", g, 16'(tx), 16'(cur[pos/CPB]));
          check("done", g, 16'(done), 16'(pos == FC - 1));
          pos++;
          if (rst || pos == FC) begin
            in_frame    = 1'b0;
            after_frame = 1'b1;
          end
        end else begin
          check("tx_idle", g, 16'(tx), 16'd1);
          check("done_idle", g, 16'(done), 16'd0);
          check("busy_idle", g, 16'(busy), 16'd0);
          after_frame = 1'b0;
        end
      end
    end
  end

  initial begin
    int cyc;
    cyc = 0;
    while (finished < N && cyc < 20000) begin
      @(posedge clk);
      cyc++;
    end
    check("drivers_finished", -1, 16'(finished), 16'(N));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
